// File: rtl/alu_slice_pkg.sv
// Shared definitions for the registered ALU slice: operation encoding and default width.
package alu_slice_pkg;

   localparam int unsigned DefaultWidth = 8;

   typedef enum logic [2:0] {
      OP_PASSB = 3'd0,
      OP_RSV1  = 3'd1,
      OP_ADD   = 3'd2,
      OP_SUB   = 3'd3,
      OP_AND   = 3'd4,
      OP_OR    = 3'd5,
      OP_XOR   = 3'd6,
      OP_RSV7  = 3'd7
   } op_e;

endpackage

// File: rtl/alu_bit_slice.sv
// One bit of the ALU: logic ops, an add full-adder and a subtract full-adder (on ~b),
// with the result picked by the operation code. Both carry chains always ripple.
module alu_bit_slice
   import alu_slice_pkg::*;
(
   input  logic a,
   input  logic b,
   input  op_e  op,
   input  logic cin_add,
   input  logic cin_sub,
   output logic res,
   output logic cout_add,
   output logic cout_sub
);

   logic sum_add;
   logic sum_sub;
   logic nb;

   assign nb       = ~b;
   assign sum_add  = a ^ b ^ cin_add;
   assign cout_add = (a & b) | (a & cin_add) | (b & cin_add);
   assign sum_sub  = a ^ nb ^ cin_sub;
   assign cout_sub = (a & nb) | (a & cin_sub) | (nb & cin_sub);

   // Select this bit's result; reserved codes drive a solid 0.
   always_comb begin
      res = 1'b0;
      unique case (op)
         OP_PASSB: res = b;
         OP_ADD:   res = sum_add;
         OP_SUB:   res = sum_sub;
         OP_AND:   res = a & b;
         OP_OR:    res = a | b;
         OP_XOR:   res = a ^ b;
         OP_RSV1,
         OP_RSV7:  res = 1'b0;
         default:  res = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_slice_reg.sv
// Registered ALU built from WIDTH bit slices with linked add/sub carry chains.
// One-cycle latency, no back-pressure; flags hold when in_valid is low.
// Optional feature: define ALU_SLICE_OVERFLOW_EN to add the signed overflow output.
module alu_slice_reg
   import alu_slice_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [2:0]       control,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             zero,
   output logic             negative
`ifdef ALU_SLICE_OVERFLOW_EN
   ,
   output logic             overflow
`endif
);

   op_e              op;
   logic [WIDTH:0]   cadd;
   logic [WIDTH:0]   csub;
   logic [WIDTH-1:0] res_d;
   logic             carry_d;

   logic             valid_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic             zero_q;

   assign op      = op_e'(control);
   assign cadd[0] = 1'b0;
   assign csub[0] = 1'b1;

   for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      alu_bit_slice u_slice (
         .a        (a[i]),
         .b        (b[i]),
         .op       (op),
         .cin_add  (cadd[i]),
         .cin_sub  (csub[i]),
         .res      (res_d[i]),
         .cout_add (cadd[i+1]),
         .cout_sub (csub[i+1])
      );
   end

   // Carry out of the MSB for whichever chain is selected; 0 for non-arithmetic ops.
   always_comb begin
      carry_d = 1'b0;
      if (op == OP_ADD) carry_d = cadd[WIDTH];
      else if (op == OP_SUB) carry_d = csub[WIDTH];
   end

   // Result and flag registers: capture on valid input, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            result_q <= res_d;
            carry_q  <= carry_d;
            zero_q   <= (res_d == '0);
         end
      end
   end

   assign out_valid = valid_q;
   assign result    = result_q;
   assign carry_out = carry_q;
   assign zero      = zero_q;
   assign negative  = result_q[WIDTH-1];

`ifdef ALU_SLICE_OVERFLOW_EN
   logic ovf_d;
   logic ovf_q;

   // Signed overflow: carry into the MSB differs from carry out of it.
   always_comb begin
      ovf_d = 1'b0;
      if (op == OP_ADD) ovf_d = cadd[WIDTH-1] ^ cadd[WIDTH];
      else if (op == OP_SUB) ovf_d = csub[WIDTH-1] ^ csub[WIDTH];
   end

   // Overflow register, updated alongside the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (in_valid) begin
         ovf_q <= ovf_d;
      end
   end

   assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu_slice_reg.sv
// Directed-vector bench for alu_slice_reg at WIDTH=8 with hand-computed expectations.
module tb_alu_slice_reg;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [2:0] control;
   logic [7:0] a;
   logic [7:0] b;
   logic       out_valid;
   logic [7:0] result;
   logic       carry_out;
   logic       zero;
   logic       negative;
`ifdef ALU_SLICE_OVERFLOW_EN
   logic       overflow;
`endif

   int n_checks = 0;
   int n_errors = 0;

   alu_slice_reg #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .control   (control),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .result    (result),
      .carry_out (carry_out),
      .zero      (zero),
      .negative  (negative)
`ifdef ALU_SLICE_OVERFLOW_EN
      ,
      .overflow  (overflow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Compare every output; ov only matters when the overflow port is built.
   task automatic expect_out(input string tag, input logic v, input logic [7:0] r,
                             input logic c, input logic z, input logic n, input logic ov);
      check({tag, ".valid"}, 64'(out_valid), 64'(v));
      check({tag, ".result"}, 64'(result), 64'(r));
      check({tag, ".carry"}, 64'(carry_out), 64'(c));
      check({tag, ".zero"}, 64'(zero), 64'(z));
      check({tag, ".neg"}, 64'(negative), 64'(n));
`ifdef ALU_SLICE_OVERFLOW_EN
      check({tag, ".ovf"}, 64'(overflow), 64'(ov));
`else
      if (ov) begin end
`endif
   endtask

   // Present one operation at the falling edge, then step past the next rising edge.
   task automatic apply(input logic v, input logic [2:0] c, input logic [7:0] x,
                        input logic [7:0] y);
      @(negedge clk);
      in_valid = v;
      control  = c;
      a        = x;
      b        = y;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      control  = 3'd0;
      a        = 8'h00;
      b        = 8'h00;
      #3;
      expect_out("reset", 0, 8'h00, 0, 0, 0, 0);

      // Operation on an edge with reset still low is discarded.
      apply(1, 3'd2, 8'hF0, 8'h20);
      expect_out("rst_discard", 0, 8'h00, 0, 0, 0, 0);
      rst_n = 1'b1;

      apply(1, 3'd2, 8'hF0, 8'h20);
      expect_out("add_f0_20", 1, 8'h10, 1, 0, 0, 0);
      apply(1, 3'd2, 8'h7F, 8'h01);
      expect_out("add_7f_01", 1, 8'h80, 0, 0, 1, 1);

      apply(1, 3'd3, 8'h05, 8'h05);
      expect_out("sub_5_5", 1, 8'h00, 1, 1, 0, 0);
      apply(1, 3'd3, 8'h03, 8'h05);
      expect_out("sub_3_5", 1, 8'hFE, 0, 0, 1, 0);
      apply(1, 3'd3, 8'h80, 8'h01);
      expect_out("sub_80_01", 1, 8'h7F, 1, 0, 0, 1);

      apply(1, 3'd4, 8'hCA, 8'h5C);
      expect_out("and", 1, 8'h48, 0, 0, 0, 0);
      apply(1, 3'd5, 8'hCA, 8'h5C);
      expect_out("or", 1, 8'hDE, 0, 0, 1, 0);
      apply(1, 3'd6, 8'hCA, 8'h5C);
      expect_out("xor", 1, 8'h96, 0, 0, 1, 0);
      apply(1, 3'd0, 8'hCA, 8'h5C);
      expect_out("passb", 1, 8'h5C, 0, 0, 0, 0);

      apply(1, 3'd1, 8'hFF, 8'hFF);
      expect_out("rsv1", 1, 8'h00, 0, 1, 0, 0);
      apply(1, 3'd7, 8'hFF, 8'hFF);
      expect_out("rsv7", 1, 8'h00, 0, 1, 0, 0);

      // Back-to-back stream, then idle cycles holding the last result.
      apply(1, 3'd6, 8'h0F, 8'hF0);
      expect_out("b2b0", 1, 8'hFF, 0, 0, 1, 0);
      apply(1, 3'd2, 8'hFF, 8'h01);
      expect_out("b2b1", 1, 8'h00, 1, 1, 0, 0);
      apply(1, 3'd3, 8'h10, 8'h01);
      expect_out("b2b2", 1, 8'h0F, 1, 0, 0, 0);
      apply(0, 3'd2, 8'h11, 8'h11);
      expect_out("idle0", 0, 8'h0F, 1, 0, 0, 0);
      apply(0, 3'd4, 8'hFF, 8'hFF);
      expect_out("idle1", 0, 8'h0F, 1, 0, 0, 0);

      // Asynchronous reset mid-stream clears outputs before the next edge.
      apply(1, 3'd2, 8'h7F, 8'h81);
      expect_out("pre_rst", 1, 8'h00, 1, 1, 0, 0);
      apply(1, 3'd6, 8'hC0, 8'h01);
      expect_out("pre_rst2", 1, 8'hC1, 0, 0, 1, 0);
      #1;
      rst_n = 1'b0;
      #1;
      expect_out("async_rst", 0, 8'h00, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      expect_out("rst_hold", 0, 8'h00, 0, 0, 0, 0);
      rst_n = 1'b1;
      apply(1, 3'd0, 8'h00, 8'h3C);
      expect_out("post_rst", 1, 8'h3C, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
